// File: rtl/us_timming_scheduler_if.sv
// -----------------------------------------------------------------------------
// us_timming_scheduler_if
// Downstream frame stream between the timing scheduler and the framer.
//   master : scheduler side, drives valid/data/last/chn, samples ready
//   slave  : framer side, samples valid/data/last/chn, drives ready
// Signals:
//   us_frame_valid_o  beat valid
//   us_frame_ready_i  downstream accepts the beat
//   us_frame_data_o   128-bit beat
//   us_frame_last_o   final beat of the frame
//   us_frame_chn_o    index of the cache that sourced the frame
// -----------------------------------------------------------------------------
interface us_timming_scheduler_if #(
    parameter int CHN_W = 7
) ();
    logic               us_frame_valid_o;
    logic               us_frame_ready_i;
    logic [127:0]       us_frame_data_o;
    logic               us_frame_last_o;
    logic [CHN_W-1:0]   us_frame_chn_o;

    modport master (
        output us_frame_valid_o,
        output us_frame_data_o,
        output us_frame_last_o,
        output us_frame_chn_o,
        input  us_frame_ready_i
    );

    modport slave (
        input  us_frame_valid_o,
        input  us_frame_data_o,
        input  us_frame_last_o,
        input  us_frame_chn_o,
        output us_frame_ready_i
    );
endinterface

// File: rtl/us_timming_scheduler.sv
// -----------------------------------------------------------------------------
// us_timming_scheduler
// Read-side engine for the upstream timing caches. Caches are drained in
// round-robin order, one complete frame at a time; a cache is only granted
// once its whole frame (length taken from header bits [11:0]) is resident,
// so a frame is never interrupted mid-stream. Malformed headers (L=0 or
// L>MAX_LEN) are popped and dropped with an error pulse and a saturating
// error count.
// Ports:
//   sys_clk_i                 system clock
//   rst_n_i                   asynchronous active-low reset
//   us_timming_rd_en_o        per-cache pop strobe (at most one bit high)
//   us_timming_dout_i         per-cache FWFT head word, 128 bits each
//   us_timming_empty_i        per-cache empty flag
//   us_timming_cache_count_i  per-cache occupancy in beats, 12 bits each
//   us_frame                  downstream frame stream (master modport)
//   us_frame_err_o            one-cycle pulse per dropped header
//   us_frame_err_cnt_o        saturating count of dropped headers
// -----------------------------------------------------------------------------
module us_timming_scheduler #(
    parameter int TOTAL_NUM = 104,
    parameter int CHN_W     = 7,
    parameter int MAX_LEN   = 2048
) (
    input  logic                        sys_clk_i,
    input  logic                        rst_n_i,
    output logic [TOTAL_NUM-1:0]        us_timming_rd_en_o,
    input  logic [TOTAL_NUM*128-1:0]    us_timming_dout_i,
    input  logic [TOTAL_NUM-1:0]        us_timming_empty_i,
    input  logic [TOTAL_NUM*12-1:0]     us_timming_cache_count_i,
    us_timming_scheduler_if.master      us_frame,
    output logic                        us_frame_err_o,
    output logic [15:0]                 us_frame_err_cnt_o
);

    typedef enum logic [1:0] {
        ST_PICK  = 2'd0,
        ST_CHECK = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    // Next cache index after c, wrapping TOTAL_NUM-1 back to 0.
    function automatic logic [CHN_W-1:0] f_next_chn(input logic [CHN_W-1:0] c);
        logic [CHN_W-1:0] n;
        if (c == CHN_W'(TOTAL_NUM - 1)) begin
            n = '0;
        end else begin
            n = c + CHN_W'(1);
        end
        return n;
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CHN_W-1:0]       r_rr_ptr;
    logic [CHN_W-1:0]       w_rr_ptr_nxt;
    logic [CHN_W-1:0]       r_sel;
    logic [CHN_W-1:0]       w_sel_nxt;
    logic [11:0]            r_beats_left;
    logic [11:0]            w_beats_left_nxt;

    // Registered copy of the non-empty vector. PICK uses it ANDed with the
    // live flags: a cache first seen non-empty in cycle T is picked in T+1,
    // and a cache drained on the previous edge is never picked stale.
    logic [TOTAL_NUM-1:0]   r_nonempty;
    logic [TOTAL_NUM-1:0]   w_cand_mask;

    logic                   w_found;
    logic [CHN_W-1:0]       w_pick;
    logic [CHN_W-1:0]       w_idx;

    logic [127:0]           w_head;
    logic [11:0]            w_len;
    logic [11:0]            w_count;
    logic                   w_sel_empty;

    logic                   w_pop;
    logic                   w_err_pop;
    logic [TOTAL_NUM-1:0]   w_rd_en;

    logic                   r_valid;
    logic [127:0]           r_data;
    logic                   r_last;
    logic [CHN_W-1:0]       r_chn;
    logic                   r_err;
    logic [15:0]            r_err_cnt;

    assign w_cand_mask = r_nonempty & ~us_timming_empty_i;
    assign w_head      = us_timming_dout_i[int'(r_sel) * 128 +: 128];
    assign w_len       = w_head[11:0];
    assign w_count     = us_timming_cache_count_i[int'(r_sel) * 12 +: 12];
    assign w_sel_empty = us_timming_empty_i[r_sel];

    // Round-robin search: first candidate at or after rr_ptr. The scan runs
    // from the farthest offset down to offset 0 so the nearest hit wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = TOTAL_NUM - 1; i >= 0; i--) begin
            w_idx   = ((int'(r_rr_ptr) + i) >= TOTAL_NUM)
                    ? CHN_W'(int'(r_rr_ptr) + i - TOTAL_NUM)
                    : CHN_W'(int'(r_rr_ptr) + i);
            w_found = w_found | w_cand_mask[w_idx];
            w_pick  = w_cand_mask[w_idx] ? w_idx : w_pick;
        end
    end

    // Next-state logic, pop decision and round-robin pointer update.
    always_comb begin
        w_state_nxt      = r_state;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_sel_nxt        = r_sel;
        w_beats_left_nxt = r_beats_left;
        w_pop            = 1'b0;
        w_err_pop        = 1'b0;
        case (r_state)
            ST_PICK: begin
                if (w_found) begin
                    w_sel_nxt   = w_pick;
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_state_nxt = ST_PICK;
                end
            end
            ST_CHECK: begin
                if (w_sel_empty) begin
                    // Nothing to inspect; retry the search without advancing.
                    w_state_nxt = ST_PICK;
                end else if ((w_len == 12'd0) || (w_len > 12'(MAX_LEN))) begin
                    w_err_pop    = 1'b1;
                    w_rr_ptr_nxt = f_next_chn(r_sel);
                    w_state_nxt  = ST_PICK;
                end else if (w_count < w_len) begin
                    // Frame not fully resident: skip this cache for now.
                    w_rr_ptr_nxt = f_next_chn(r_sel);
                    w_state_nxt  = ST_PICK;
                end else begin
                    w_beats_left_nxt = w_len;
                    w_state_nxt      = ST_SEND;
                end
            end
            ST_SEND: begin
                w_pop = (r_beats_left != 12'd0)
                      && (!r_valid || us_frame.us_frame_ready_i)
                      && !w_sel_empty;
                if (w_pop) begin
                    w_beats_left_nxt = r_beats_left - 12'd1;
                    if (r_beats_left == 12'd1) begin
                        w_rr_ptr_nxt = f_next_chn(r_sel);
                        w_state_nxt  = ST_PICK;
                    end else begin
                        w_state_nxt  = ST_SEND;
                    end
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            default: begin
                w_state_nxt = ST_PICK;
            end
        endcase
    end

    // Pop strobe: only the selected cache, only on a data or error pop.
    always_comb begin
        w_rd_en = '0;
        if (w_pop || w_err_pop) begin
            w_rd_en[r_sel] = 1'b1;
        end else begin
            w_rd_en = '0;
        end
    end

    // FSM state, selection, pointer and beat counter registers.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_PICK;
            r_rr_ptr     <= '0;
            r_sel        <= '0;
            r_beats_left <= 12'd0;
            r_nonempty   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_sel        <= w_sel_nxt;
            r_beats_left <= w_beats_left_nxt;
            r_nonempty   <= ~us_timming_empty_i;
        end
    end

    // Output beat register: loads on a pop, drains when accepted, holds on stall.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid <= 1'b0;
            r_data  <= 128'd0;
            r_last  <= 1'b0;
            r_chn   <= '0;
        end else if (w_pop) begin
            r_valid <= 1'b1;
            r_data  <= w_head;
            r_last  <= (r_beats_left == 12'd1);
            r_chn   <= r_sel;
        end else if (us_frame.us_frame_ready_i) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Error pulse and saturating error counter for dropped headers.
    always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_err     <= 1'b0;
            r_err_cnt <= 16'd0;
        end else begin
            r_err <= w_err_pop;
            if (w_err_pop && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end else begin
                r_err_cnt <= r_err_cnt;
            end
        end
    end

    assign us_timming_rd_en_o        = w_rd_en;
    assign us_frame.us_frame_valid_o = r_valid;
    assign us_frame.us_frame_data_o  = r_data;
    assign us_frame.us_frame_last_o  = r_last;
    assign us_frame.us_frame_chn_o   = r_chn;
    assign us_frame_err_o            = r_err;
    assign us_frame_err_cnt_o        = r_err_cnt;

endmodule

// File: tb/tb_us_timming_scheduler.sv
// -----------------------------------------------------------------------------
// tb_us_timming_scheduler
// Models the 104 FWFT timing caches as queues, pushes the expected output
// beats into a scoreboard when frames are loaded, and compares each accepted
// beat against the scoreboard head.
// -----------------------------------------------------------------------------
module tb_us_timming_scheduler;

    localparam int TOTAL_NUM = 104;
    localparam int CHN_W     = 7;
    localparam int MAX_LEN   = 2048;

    logic                       sys_clk_i = 1'b0;
    logic                       rst_n_i;
    logic [TOTAL_NUM-1:0]       rd_en;
    logic [TOTAL_NUM*128-1:0]   dout;
    logic [TOTAL_NUM-1:0]       empty;
    logic [TOTAL_NUM*12-1:0]    cnt;
    logic                       err;
    logic [15:0]                err_cnt;

    us_timming_scheduler_if #(.CHN_W(CHN_W)) u_if ();

    us_timming_scheduler #(
        .TOTAL_NUM (TOTAL_NUM),
        .CHN_W     (CHN_W),
        .MAX_LEN   (MAX_LEN)
    ) u_dut (
        .sys_clk_i                (sys_clk_i),
        .rst_n_i                  (rst_n_i),
        .us_timming_rd_en_o       (rd_en),
        .us_timming_dout_i        (dout),
        .us_timming_empty_i       (empty),
        .us_timming_cache_count_i (cnt),
        .us_frame                 (u_if),
        .us_frame_err_o           (err),
        .us_frame_err_cnt_o       (err_cnt)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    logic [127:0]         cache_q [TOTAL_NUM][$];
    logic [143:0]         exp_q[$];
    logic [127:0]         frm[$];
    logic [127:0]         frm_saved[$];

    int checks      = 0;
    int failures    = 0;
    int cyc         = 0;
    int beats_seen  = 0;
    int err_pulses  = 0;
    int stall_cnt   = 0;
    int rise_cyc    = -1;
    int pop_cnt   [TOTAL_NUM];
    int pop_first [TOTAL_NUM];
    int pop_last  [TOTAL_NUM];

    logic [TOTAL_NUM-1:0] pending_pop = '0;
    logic                 live_rst;
    logic                 bp_mode = 1'b0;
    logic                 prev_stall = 1'b0;
    logic                 prev_valid = 1'b0;
    logic [143:0]         prev_beat;
    logic [143:0]         cur;

    task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        for (int ch = 0; ch < TOTAL_NUM; ch++) begin
            empty[ch]             = (cache_q[ch].size() == 0);
            cnt[ch*12 +: 12]      = 12'(cache_q[ch].size());
            dout[ch*128 +: 128]   = (cache_q[ch].size() != 0) ? cache_q[ch][0] : 128'd0;
        end
    endtask

    // Build a frame in frm: header carries hdr_len in [11:0], nbeats beats total.
    task automatic build(input int hdr_len, input int nbeats);
        logic [127:0] w;
        frm.delete();
        for (int i = 0; i < nbeats; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0) w[11:0] = 12'(hdr_len);
            frm.push_back(w);
        end
    endtask

    task automatic feed(input int ch, input int lo, input int hi);
        for (int i = lo; i < hi; i++) cache_q[ch].push_back(frm[i]);
    endtask

    task automatic expect_frame(input int ch);
        for (int i = 0; i < frm.size(); i++)
            exp_q.push_back({8'd0, 7'(ch), (i == frm.size() - 1), frm[i]});
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((exp_q.size() != 0 || u_if.us_frame_valid_o) && n < max_cyc) begin
            @(negedge sys_clk_i);
            n++;
        end
        chk("drain_left", 144'(exp_q.size()), 144'd0);
        repeat (3) @(negedge sys_clk_i);
    endtask

    // Cache side: apply pops seen before this edge, then update cache outputs and ready.
    always @(posedge sys_clk_i) begin
        cyc++;
        live_rst = rst_n_i;
        #1;
        if (live_rst) begin
            for (int ch = 0; ch < TOTAL_NUM; ch++) begin
                if (pending_pop[ch]) begin
                    chk("pop_nonempty", 144'(cache_q[ch].size() != 0), 144'd1);
                    if (cache_q[ch].size() != 0) void'(cache_q[ch].pop_front());
                    if (pop_cnt[ch] == 0) pop_first[ch] = cyc;
                    pop_last[ch] = cyc;
                    pop_cnt[ch]++;
                end
            end
        end
        refresh();
        if (bp_mode) u_if.us_frame_ready_i = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        else         u_if.us_frame_ready_i = 1'b1;
    end

    // Monitor: scoreboard compare on accepted beats plus handshake rules.
    always @(negedge sys_clk_i) begin
        cur = {8'd0, u_if.us_frame_chn_o, u_if.us_frame_last_o, u_if.us_frame_data_o};
        if (rst_n_i) begin
            pending_pop = rd_en;
            if (rd_en != '0) chk("rd_onehot", 144'($countones(rd_en)), 144'd1);
            if (u_if.us_frame_valid_o && !u_if.us_frame_ready_i) begin
                chk("bp_nopop", 144'(rd_en), 144'd0);
                stall_cnt++;
            end
            if (prev_stall) chk("stall_hold", cur, prev_beat);
            if (u_if.us_frame_valid_o && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
            if (u_if.us_frame_valid_o && u_if.us_frame_ready_i) begin
                chk("sb_nonempty", 144'(exp_q.size() != 0), 144'd1);
                if (exp_q.size() != 0) chk("beat", cur, exp_q.pop_front());
                beats_seen++;
            end
            if (err) err_pulses++;
            prev_stall = u_if.us_frame_valid_o && !u_if.us_frame_ready_i;
            prev_valid = u_if.us_frame_valid_o;
            prev_beat  = cur;
        end else begin
            pending_pop = '0;
            prev_stall  = 1'b0;
            prev_valid  = 1'b0;
        end
    end

    initial begin
        int load_cyc;
        int base;
        int n;
        rst_n_i = 1'b0;
        repeat (3) @(negedge sys_clk_i);
        chk("rst_valid",  144'(u_if.us_frame_valid_o), 144'd0);
        chk("rst_rd_en",  144'(rd_en), 144'd0);
        chk("rst_data",   144'(u_if.us_frame_data_o), 144'd0);
        chk("rst_last",   144'(u_if.us_frame_last_o), 144'd0);
        chk("rst_chn",    144'(u_if.us_frame_chn_o), 144'd0);
        chk("rst_err",    144'(err), 144'd0);
        chk("rst_errcnt", 144'(err_cnt), 144'd0);
        rst_n_i = 1'b1;
        repeat (3) @(negedge sys_clk_i);

        // Single frame on cache 5; contents become visible after the next edge.
        build(4, 4);
        feed(5, 0, 4);
        expect_frame(5);
        load_cyc = cyc + 1;
        drain(60);
        chk("latency",      144'(rise_cyc - load_cyc), 144'd4);
        chk("pop5_cnt",     144'(pop_cnt[5]), 144'd4);
        chk("pop5_consec",  144'(pop_last[5] - pop_first[5]), 144'd3);

        // Round-robin: serve 31 to bring rr_ptr to 32, then 0/31/103 together.
        build(1, 1); feed(31, 0, 1); expect_frame(31);
        drain(60);
        build(1, 1); feed(103, 0, 1); expect_frame(103);
        build(1, 1); feed(0, 0, 1);   expect_frame(0);
        build(1, 1); feed(31, 0, 1);  expect_frame(31);
        drain(80);
        // rr_ptr should be back at 32: 32 must win over 31.
        build(1, 1); feed(32, 0, 1);  expect_frame(32);
        build(1, 1); feed(31, 0, 1);  expect_frame(31);
        drain(80);

        // Incomplete frame on 10 is skipped; 11 served; 10 served once complete.
        build(6, 6); frm_saved = frm; feed(10, 0, 3);
        build(2, 2); feed(11, 0, 2); expect_frame(11);
        drain(80);
        repeat (10) @(negedge sys_clk_i);
        chk("incomplete_held", 144'(cache_q[10].size()), 144'd3);
        frm = frm_saved; feed(10, 3, 6); expect_frame(10);
        drain(80);

        // Backpressure with ready pattern 1,0,0,1.
        bp_mode = 1'b1;
        build(8, 8); feed(7, 0, 8); expect_frame(7);
        drain(200);
        bp_mode = 1'b0;
        chk("bp_stalls_seen", 144'(stall_cnt > 0), 144'd1);

        // Malformed headers on cache 2.
        base = err_pulses;
        build(0, 1); feed(2, 0, 1);
        repeat (10) @(negedge sys_clk_i);
        chk("err0_pulses", 144'(err_pulses - base), 144'd1);
        chk("err0_cnt",    144'(err_cnt), 144'd1);
        chk("err0_popped", 144'(cache_q[2].size()), 144'd0);
        build(2049, 1); feed(2, 0, 1);
        repeat (10) @(negedge sys_clk_i);
        chk("err2049_pulses", 144'(err_pulses - base), 144'd2);
        chk("err2049_cnt",    144'(err_cnt), 144'd2);
        chk("err2049_popped", 144'(cache_q[2].size()), 144'd0);

        // Largest legal frame.
        build(MAX_LEN, MAX_LEN); feed(50, 0, MAX_LEN); expect_frame(50);
        drain(2300);
        chk("maxlen_errcnt", 144'(err_cnt), 144'd2);

        // Reset during beat 3 of 8.
        base = beats_seen;
        build(8, 8); feed(20, 0, 8); expect_frame(20);
        n = 0;
        while (beats_seen < base + 2 && n < 60) begin
            @(negedge sys_clk_i);
            n++;
        end
        chk("mid_reached", 144'(beats_seen - base), 144'd2);
        #2 rst_n_i = 1'b0;
        #1;
        chk("mid_valid",  144'(u_if.us_frame_valid_o), 144'd0);
        chk("mid_rd_en",  144'(rd_en), 144'd0);
        chk("mid_errcnt", 144'(err_cnt), 144'd0);
        // Upstream discards the rest of the frame while reset is held.
        exp_q.delete();
        cache_q[20].delete();
        repeat (3) @(negedge sys_clk_i);
        rst_n_i = 1'b1;
        @(negedge sys_clk_i);
        chk("post_errcnt", 144'(err_cnt), 144'd0);
        // rr_ptr back at 0: cache 0 before cache 103.
        build(1, 1); feed(0, 0, 1);   expect_frame(0);
        build(1, 1); feed(103, 0, 1); expect_frame(103);
        drain(80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
